// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the switch-driven program loader.
// Optional debounce is selected with PROG_DEBOUNCE_EN.
package prog_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    WRITE,
    ADVANCE
  } state_e;

  function automatic int beats(input int data_w, input int sw_w);
    return data_w / sw_w;
  endfunction

  function automatic bit width_ok(input int data_w, input int sw_w);
    return (sw_w > 0) && (data_w >= sw_w) && (data_w % sw_w == 0);
  endfunction

endpackage

// File: rtl/prog_loader_btn_edge.sv
// Push-button conditioning: 2-flop sync, optional debounce, edge pulse.
// Debounce counter is present only when PROG_DEBOUNCE_EN is defined.
module btn_edge #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic ep_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

`ifdef PROG_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d, dbp_q;

  // Level flips only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
      dbp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
      dbp_q <= db_q;
    end
  end

  assign ep_o = db_q & ~dbp_q;
`else
  logic s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s3_q <= 1'b0;
    end else begin
      s3_q <= s2_q;
    end
  end

  assign ep_o = s2_q & ~s3_q;
`endif

endmodule

// File: rtl/prog_loader.sv
// Front-panel program loader: packs switch beats into RAM words.
// Build with PROG_DEBOUNCE_EN to debounce the enter button.
module prog_loader
  import prog_pkg::*;
#(
  parameter int          SW_W      = 8,
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 8,
  parameter int unsigned LAST_ADDR = 2**ADDR_W - 1,
  parameter int          DB_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SW_W-1:0]              switch,
  input  logic                         enter,
  input  logic                         addr_set,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic                         wr_en,
  output logic [$clog2(DATA_W/SW_W):0] beat_idx,
  output logic                         full
);

  localparam int BEATS = beats(DATA_W, SW_W);
  localparam int BI_W  = $clog2(BEATS) + 1;

  if (!width_ok(DATA_W, SW_W)) begin : g_width_chk
    $error("prog_loader: DATA_W must be a multiple of SW_W");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BI_W-1:0]   beat_q, beat_d;
  logic              full_q, full_d;
  logic              ep;

  btn_edge #(
    .DB_CYCLES(DB_CYCLES)
  ) u_enter (
    .clk_i (clk),
    .rst_ni(rst),
    .btn_i (enter),
    .ep_o  (ep)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    beat_d  = beat_q;
    full_d  = full_q;
    unique case (state_q)
      COLLECT: begin
        if (ep) begin
          if (addr_set) begin
            addr_d = ADDR_W'(switch);
            beat_d = '0;
            full_d = 1'b0;
          end else if (!full_q) begin
            // MSB beat first: beat k lands in slice k from the top.
            for (int k = 0; k < BEATS; k++) begin
              if (beat_q == BI_W'(k)) begin
                data_d[DATA_W-1-k*SW_W -: SW_W] = switch;
              end
            end
            if (beat_q == BI_W'(BEATS - 1)) begin
              beat_d  = '0;
              state_d = WRITE;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
      end
      WRITE: begin
        state_d = ADVANCE;
      end
      ADVANCE: begin
        if (addr_q == ADDR_W'(LAST_ADDR)) begin
          full_d = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
        state_d = COLLECT;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      addr_q  <= '0;
      data_q  <= '0;
      beat_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
      full_q  <= full_d;
    end
  end

  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign wr_en    = (state_q == WRITE);
  assign beat_idx = beat_q;
  assign full     = full_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: three widths share one panel, checked
// against a word-level model of the loader.
module tb_prog_loader;

`ifdef PROG_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int HOLD = DB + 4;
  localparam int GAP  = DB + 6;
  localparam int ND   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enter = 1'b0;
  logic       addr_set = 1'b0;
  logic [7:0] sw = 8'h00;

  always #5 clk = ~clk;

  logic [7:0]  a0, a1, a2;
  logic [15:0] d0;
  logic [23:0] d1;
  logic [7:0]  d2;
  logic [1:0]  b0;
  logic [2:0]  b1;
  logic [0:0]  b2;
  logic [2:0]  we, fl;

  prog_loader #(.SW_W(8), .DATA_W(16), .ADDR_W(8),
    .LAST_ADDR(255), .DB_CYCLES(16)) u_dut0 (
    .clk(clk), .rst(rst), .switch(sw), .enter(enter),
    .addr_set(addr_set), .wr_addr(a0), .wr_data(d0),
    .wr_en(we[0]), .beat_idx(b0), .full(fl[0]));

  prog_loader #(.SW_W(8), .DATA_W(24), .ADDR_W(8),
    .LAST_ADDR(255), .DB_CYCLES(16)) u_dut1 (
    .clk(clk), .rst(rst), .switch(sw), .enter(enter),
    .addr_set(addr_set), .wr_addr(a1), .wr_data(d1),
    .wr_en(we[1]), .beat_idx(b1), .full(fl[1]));

  prog_loader #(.SW_W(8), .DATA_W(8), .ADDR_W(8),
    .LAST_ADDR(255), .DB_CYCLES(16)) u_dut2 (
    .clk(clk), .rst(rst), .switch(sw), .enter(enter),
    .addr_set(addr_set), .wr_addr(a2), .wr_data(d2),
    .wr_en(we[2]), .beat_idx(b2), .full(fl[2]));

  function automatic logic [7:0] addr_of(int d);
    case (d)
      0: return a0;
      1: return a1;
      default: return a2;
    endcase
  endfunction

  function automatic logic [31:0] data_of(int d);
    case (d)
      0: return 32'(d0);
      1: return 32'(d1);
      default: return 32'(d2);
    endcase
  endfunction

  function automatic logic [31:0] beat_of(int d);
    case (d)
      0: return 32'(b0);
      1: return 32'(b1);
      default: return 32'(b2);
    endcase
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Word-level model: beats per word, pointer, word image, full flag.
  int          nb[ND] = '{2, 3, 1};
  logic [7:0]  m_addr[ND];
  logic [31:0] m_data[ND];
  int          m_beat[ND];
  bit          m_full[ND];
  bit          m_wrote[ND];

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t expq[$];

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_addr[d]  = 8'h00;
      m_data[d]  = 32'h0;
      m_beat[d]  = 0;
      m_full[d]  = 1'b0;
      m_wrote[d] = 1'b0;
    end
  endtask

  // close: entry lands two cycles after the previous one.
  task automatic model_entry(logic [7:0] v, bit aset, bit close);
    int sh;
    for (int d = 0; d < ND; d++) begin
      if (close && m_wrote[d]) continue;
      m_wrote[d] = 1'b0;
      if (aset) begin
        m_addr[d] = v;
        m_beat[d] = 0;
        m_full[d] = 1'b0;
      end else if (!m_full[d]) begin
        sh = 8 * (nb[d] - 1 - m_beat[d]);
        m_data[d] = (m_data[d] & ~(32'hFF << sh)) | (32'(v) << sh);
        m_beat[d]++;
        if (m_beat[d] == nb[d]) begin
          expq.push_back(wr_t'{d, m_addr[d], m_data[d]});
          m_beat[d]  = 0;
          m_wrote[d] = 1'b1;
          if (m_addr[d] == 8'hFF) m_full[d] = 1'b1;
          else m_addr[d] = m_addr[d] + 8'h01;
        end
      end
    end
  endtask

  int          cyc = 0;
  int          pend[ND] = '{-10, -10, -10};
  logic [7:0]  pend_a[ND];
  logic [7:0]  lw_a[ND];
  logic [31:0] lw_d[ND];
  int          lw_cyc[ND];
  int          nwr[ND] = '{0, 0, 0};

  always @(negedge clk) begin : cmp
    int idx;
    cyc++;
    for (int d = 0; d < ND; d++) begin
      if (we[d]) begin
        idx = -1;
        foreach (expq[i]) if (idx < 0 && expq[i].id == d) idx = i;
        if (idx < 0) begin
          checks++;
          errors++;
          $display("FAIL d%0d.unexpected_wr_en addr=%0h data=%0h",
                   d, addr_of(d), data_of(d));
        end else begin
          check($sformatf("d%0d.wr_addr_at_wr", d), 32'(addr_of(d)),
                32'(expq[idx].a));
          check($sformatf("d%0d.wr_data_at_wr", d), data_of(d),
                expq[idx].d);
          expq.delete(idx);
        end
        pend[d]   = cyc;
        pend_a[d] = addr_of(d);
        lw_a[d]   = addr_of(d);
        lw_d[d]   = data_of(d);
        lw_cyc[d] = cyc;
        nwr[d]++;
      end
      if (cyc == pend[d] + 1) begin
        check($sformatf("d%0d.addr_hold", d), 32'(addr_of(d)),
              32'(pend_a[d]));
        check($sformatf("d%0d.wr_en_one", d), 32'(we[d]), 32'd0);
      end
      if (cyc == pend[d] + 2) begin
        check($sformatf("d%0d.addr_next", d), 32'(addr_of(d)),
              (pend_a[d] == 8'hFF) ? 32'hFF : 32'(pend_a[d]) + 1);
        check($sformatf("d%0d.full_after", d), 32'(fl[d]),
              32'(pend_a[d] == 8'hFF));
      end
    end
  end

  task automatic check_all(string tag);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s.d%0d.wr_addr", tag, d), 32'(addr_of(d)),
            32'(m_addr[d]));
      check($sformatf("%s.d%0d.wr_data", tag, d), data_of(d), m_data[d]);
      check($sformatf("%s.d%0d.beat_idx", tag, d), beat_of(d),
            32'(m_beat[d]));
      check($sformatf("%s.d%0d.full", tag, d), 32'(fl[d]),
            32'(m_full[d]));
      check($sformatf("%s.d%0d.wr_en", tag, d), 32'(we[d]), 32'd0);
    end
  endtask

  int press_cyc;

  task automatic press(logic [7:0] v, bit aset, int hold = HOLD);
    model_entry(v, aset, 1'b0);
    @(posedge clk);
    #1;
    sw        = v;
    addr_set  = aset;
    enter     = 1'b1;
    press_cyc = cyc;
    repeat (hold) @(posedge clk);
    #1 enter = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
  endtask

  int n0;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.a0", 32'(a0), 32'h0);
    check("reset.d0", 32'(d0), 32'h0);
    check("reset.b0", 32'(b0), 32'h0);
    check_all("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    press(8'hAB, 1'b0);
    press(8'hCD, 1'b0);
    check("t1.latency", 32'(lw_cyc[0] - press_cyc), 32'(4 + DB));
    check("t1.wdata", lw_d[0], 32'hABCD);
    check("t1.waddr", 32'(lw_a[0]), 32'h00);
    check("t1.next", 32'(a0), 32'h01);
    check("t1.beat", 32'(b0), 32'h0);
    check("t1.d1beat", 32'(b1), 32'h2);
    check_all("t1");

    press(8'h40, 1'b1);
    press(8'h12, 1'b0);
    press(8'h34, 1'b0);
    check("t2.wdata", lw_d[0], 32'h1234);
    check("t2.waddr", 32'(lw_a[0]), 32'h40);
    check("t2.next", 32'(a0), 32'h41);
    check_all("t2");

`ifndef PROG_DEBOUNCE_EN
    press(8'h10, 1'b1);
    press(8'hA1, 1'b0);
    model_entry(8'hB2, 1'b0, 1'b0);
    model_entry(8'hB2, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    sw = 8'hB2;
    addr_set = 1'b0;
    enter = 1'b1;
    @(posedge clk);
    #1 enter = 1'b0;
    @(posedge clk);
    #1 enter = 1'b1;
    @(posedge clk);
    #1 enter = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    check("drop.wdata0", lw_d[0], 32'hA1B2);
    check("drop.next0", 32'(a0), 32'h11);
    check("drop.beat0", 32'(b0), 32'h0);
    check("drop.wdata1", lw_d[1], 32'hA1B2B2);
    check("drop.next2", 32'(a2), 32'h12);
    check_all("drop");
`endif

    press(8'hFF, 1'b1);
    press(8'h5A, 1'b0);
    press(8'hC3, 1'b0);
    check("full.waddr", 32'(lw_a[0]), 32'hFF);
    check("full.wdata", lw_d[0], 32'h5AC3);
    check("full.flag", 32'(fl[0]), 32'h1);
    check("full.hold", 32'(a0), 32'hFF);
    n0 = nwr[0];
    press(8'h99, 1'b0);
    check("full.ignored_wr", 32'(nwr[0]), 32'(n0));
    check("full.ignored_beat", 32'(b0), 32'h0);
    check("full.still", 32'(fl[0]), 32'h1);
    press(8'h00, 1'b1);
    check("full.cleared", 32'(fl[0]), 32'h0);
    check_all("full");

    press(8'h77, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst.d0", 32'(d0), 32'h0);
    check("rst.b0", 32'(b0), 32'h0);
    check_all("rst");
    @(posedge clk);
    #1 rst = 1'b1;
    press(8'h12, 1'b0);
    press(8'h34, 1'b0);
    check("rst.wdata", lw_d[0], 32'h1234);
    check("rst.waddr", 32'(lw_a[0]), 32'h00);
    check("rst.next", 32'(a0), 32'h01);
    check_all("after_rst");

    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    press(8'h01, 1'b0);
    press(8'h02, 1'b0);
    press(8'h03, 1'b0);
    check("w24.wdata", lw_d[1], 32'h010203);
    check("w24.waddr", 32'(lw_a[1]), 32'h00);
    check("w24.next", 32'(a1), 32'h01);
    check("w8.wdata", lw_d[2], 32'h03);
    check("w8.next", 32'(a2), 32'h03);
    check("w16.partial", 32'(d0), 32'h0302);
    check_all("w24");

`ifdef PROG_DEBOUNCE_EN
    @(posedge clk);
    #1;
    sw = 8'h55;
    addr_set = 1'b0;
    enter = 1'b1;
    repeat (5) @(posedge clk);
    #1 enter = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    check("glitch.beat0", 32'(b0), 32'h1);
    check_all("glitch");
    press(8'h66, 1'b0, 40);
    check("db.latency", 32'(lw_cyc[0] - press_cyc), 32'(4 + DB));
    check("db.wdata", lw_d[0], 32'h0366);
    check_all("db");
`endif

    check("expq_empty", 32'(expq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
